// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// One operation in flight: IDLE accepts, EXEC captures the ALU result, RESP holds it until accepted.
module alu_share_arbiter #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned CTRL_W = 4,
  parameter int unsigned MAX_OP = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic [2*WIDTH-1:0]  req_op1,
  input  logic [2*WIDTH-1:0]  req_op2,
  input  logic [2*CTRL_W-1:0] req_ctrl,
  output logic [1:0]          rsp_valid,
  input  logic [1:0]          rsp_ready,
  output logic [WIDTH-1:0]    rsp_res,
  output logic                rsp_zero,
  output logic                rsp_err,
  output logic [WIDTH-1:0]    alu_op1,
  output logic [WIDTH-1:0]    alu_op2,
  output logic [CTRL_W-1:0]   alu_ctrl,
  input  logic [WIDTH-1:0]    alu_res,
  input  logic                alu_zero
);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e              state_q;
  logic                rr_ptr_q;
  logic                grant_q;
  logic [WIDTH-1:0]    op1_q;
  logic [WIDTH-1:0]    op2_q;
  logic [CTRL_W-1:0]   ctrl_q;
  logic [1:0]          rsp_valid_q;
  logic [WIDTH-1:0]    rsp_res_q;
  logic                rsp_zero_q;
  logic                rsp_err_q;

  logic                win_valid;
  logic                win;
  logic                illegal;

  // Winner: the priority port if it asks, otherwise the other one.
  always_comb begin
    win_valid = 1'b0;
    win       = rr_ptr_q;
    if (state_q == StIdle) begin
      if (req_valid[rr_ptr_q]) begin
        win_valid = 1'b1;
        win       = rr_ptr_q;
      end else if (req_valid[~rr_ptr_q]) begin
        win_valid = 1'b1;
        win       = ~rr_ptr_q;
      end
    end
    req_ready = 2'b00;
    if (win_valid) begin
      req_ready = win ? 2'b10 : 2'b01;
    end
  end

  assign illegal = (ctrl_q > CTRL_W'(MAX_OP));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      rr_ptr_q    <= 1'b0;
      grant_q     <= 1'b0;
      op1_q       <= '0;
      op2_q       <= '0;
      ctrl_q      <= '0;
      rsp_valid_q <= 2'b00;
      rsp_res_q   <= '0;
      rsp_zero_q  <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (win_valid) begin
            op1_q   <= win ? req_op1[2*WIDTH-1:WIDTH]   : req_op1[WIDTH-1:0];
            op2_q   <= win ? req_op2[2*WIDTH-1:WIDTH]   : req_op2[WIDTH-1:0];
            ctrl_q  <= win ? req_ctrl[2*CTRL_W-1:CTRL_W] : req_ctrl[CTRL_W-1:0];
            grant_q <= win;
            state_q <= StExec;
          end
        end
        StExec: begin
          // Illegal codes report a clean zero result rather than whatever the ALU produced.
          rsp_res_q   <= illegal ? '0 : alu_res;
          rsp_zero_q  <= illegal ? 1'b1 : alu_zero;
          rsp_err_q   <= illegal;
          rsp_valid_q <= grant_q ? 2'b10 : 2'b01;
          state_q     <= StResp;
        end
        StResp: begin
          if (rsp_ready[grant_q]) begin
            rsp_valid_q <= 2'b00;
            rr_ptr_q    <= ~grant_q;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign alu_op1   = op1_q;
  assign alu_op2   = op2_q;
  assign alu_ctrl  = ctrl_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_res   = rsp_res_q;
  assign rsp_zero  = rsp_zero_q;
  assign rsp_err   = rsp_err_q;

endmodule
